// File: rtl/i2s_rx_sample_pkg.sv
// rtl/i2s_rx_sample_pkg.sv - shared constants and state encoding for the I2S sample receiver
// Holds the channel select constants, the default sample width shared with the
// notch filter wrapper, and the receiver state encoding.
package i2s_rx_sample_pkg;

  localparam int   I2S_DATA_SIZE = 24;
  localparam logic I2S_LEFT      = 1'b0;
  localparam logic I2S_RIGHT     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sample_sync_edge.sv
// rtl/i2s_rx_sample_sync_edge.sv - multi-flop synchroniser with registered level and edge outputs
// Ports:
//   clk_i   system clock
//   reset_i asynchronous active-high reset
//   d_i     asynchronous input
//   level_o synchronised level, aligned with edge_o
//   edge_o  one-clk pulse on any change of the synchronised level
module i2s_rx_sample_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   edge_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      level_q <= sync_q[SYNC_STAGES-1];
      edge_q  <= sync_q[SYNC_STAGES-1] ^ level_q;
    end
  end

  // level_o is the copy that edge_o was computed against, so a rising edge is
  // simply edge_o & level_o.
  assign level_o = level_q;
  assign edge_o  = edge_q;

endmodule

// File: rtl/i2s_rx_sample.sv
// rtl/i2s_rx_sample.sv - I2S single-channel receiver feeding the notch filter sample trigger
// Ports:
//   clk_i          system clock, at least 4x bclk
//   reset_i        asynchronous active-high reset
//   bclk_i         I2S bit clock (asynchronous)
//   lrclk_i        I2S word select (asynchronous)
//   sdin_i         I2S serial data, MSB first
//   filter_done_i  one-clk pulse: filter consumed the previous sample
//   data_out_o     last complete sample, two's complement
//   sample_o       one-clk strobe, data_out_o valid from this cycle on
//   frame_err_o    one-clk pulse when a word was truncated by lrclk
//   overrun_o      sticky: a sample was issued while the filter was busy
module i2s_rx_sample
  import i2s_rx_sample_pkg::*;
#(
  parameter int   DATA_SIZE   = I2S_DATA_SIZE,
  parameter logic CHANNEL     = I2S_LEFT,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 bclk_i,
  input  logic                 lrclk_i,
  input  logic                 sdin_i,
  input  logic                 filter_done_i,
  output logic [DATA_SIZE-1:0] data_out_o,
  output logic                 sample_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CW = $clog2(DATA_SIZE + 1);

  logic bclk_lvl, bclk_edge;
  logic lr_lvl, lr_edge;
  logic bre, lre;

  i2s_rx_sample_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (bclk_i),
    .level_o (bclk_lvl),
    .edge_o  (bclk_edge)
  );

  i2s_rx_sample_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (lrclk_i),
    .level_o (lr_lvl),
    .edge_o  (lr_edge)
  );

  // sdin gets one flop more than the synchroniser depth so that it lines up
  // with bre, which is itself one registered stage behind the synchronised bclk.
  logic [SYNC_STAGES:0] sdin_q;
  logic                 sdin_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sdin_q <= '0;
    end else begin
      sdin_q <= {sdin_q[SYNC_STAGES-1:0], sdin_i};
    end
  end

  assign sdin_s = sdin_q[SYNC_STAGES];
  assign bre    = bclk_edge & bclk_lvl;
  // lrclk moves on the falling bclk edge, so its edge always lands between two
  // bre events, ahead of the delay-slot bit. Acting on it straight away lets
  // SKIP throw away exactly that one delay-slot bit.
  assign lre    = lr_edge;

  i2s_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 sample_q, sample_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_SIZE-1:0] shift_in;
  logic [CW-1:0]        cnt_inc;

  assign shift_in = {shift_q[DATA_SIZE-2:0], sdin_s};
  assign cnt_inc  = cnt_q + CW'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      sample_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      sample_q    <= sample_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    sample_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (lre && (lr_lvl == CHANNEL)) begin
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (lre) begin
          if (lr_lvl != CHANNEL) begin
            state_d = ST_IDLE;
          end
        end else if (bre) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        // A word-select change before the word is complete wins over any bit.
        if (lre) begin
          frame_err_d = 1'b1;
          state_d     = (lr_lvl == CHANNEL) ? ST_SKIP : ST_IDLE;
        end else if (bre) begin
          shift_d = shift_in;
          cnt_d   = cnt_inc;
          if (cnt_inc == CW'(DATA_SIZE)) begin
            data_d   = shift_in;
            sample_d = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (lre) begin
          state_d = (lr_lvl == CHANNEL) ? ST_SKIP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A sample colliding with filter_done still counts as an overrun: the filter
  // had not released the previous word when the new one was presented.
  always_comb begin
    busy_d    = busy_q;
    overrun_d = overrun_q;
    if (sample_q) begin
      busy_d = 1'b1;
      if (busy_q || filter_done_i) begin
        overrun_d = 1'b1;
      end
    end else if (filter_done_i) begin
      busy_d = 1'b0;
    end
  end

  assign data_out_o  = data_q;
  assign sample_o    = sample_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_i2s_rx_sample.sv
// tb/tb_i2s_rx_sample.sv - table-driven bench for i2s_rx_sample, left and right channel instances
module tb_i2s_rx_sample;
  import i2s_rx_sample_pkg::*;

  localparam int CLK_P = 10;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b1;
  logic        lrclk = 1'b0;
  logic        sdin = 1'b0;
  logic        fd0 = 1'b0;
  logic        fd1 = 1'b0;
  logic [23:0] d0, d1;
  logic        s0, s1, fe0, fe1, ov0, ov1;

  always #(CLK_P/2) clk = ~clk;

  i2s_rx_sample #(.DATA_SIZE(24), .CHANNEL(I2S_LEFT), .SYNC_STAGES(SYNC)) u_dut_l (
    .clk_i(clk), .reset_i(reset), .bclk_i(bclk), .lrclk_i(lrclk), .sdin_i(sdin),
    .filter_done_i(fd0), .data_out_o(d0), .sample_o(s0), .frame_err_o(fe0), .overrun_o(ov0)
  );

  i2s_rx_sample #(.DATA_SIZE(24), .CHANNEL(I2S_RIGHT), .SYNC_STAGES(SYNC)) u_dut_r (
    .clk_i(clk), .reset_i(reset), .bclk_i(bclk), .lrclk_i(lrclk), .sdin_i(sdin),
    .filter_done_i(fd1), .data_out_o(d1), .sample_o(s1), .frame_err_o(fe1), .overrun_o(ov1)
  );

  int   checks = 0;
  int   errors = 0;
  int   ns0 = 0, ns1 = 0, nfe0 = 0, nfe1 = 0;
  int   tmr0 = 0, tmr1 = 0;
  bit   fd_en = 1'b1;
  time  t_s0 = 0, t_s1 = 0, t_lsb0 = 0, t_lsb1 = 0;
  logic last_bit = 1'b0;

  // Filter model: answers each sample with filter_done 20 clk later when enabled.
  always @(negedge clk) begin
    fd0 = 1'b0;
    fd1 = 1'b0;
    if (tmr0 > 0) begin tmr0--; if (tmr0 == 0) fd0 = 1'b1; end
    if (tmr1 > 0) begin tmr1--; if (tmr1 == 0) fd1 = 1'b1; end
    if (s0) begin ns0++; t_s0 = $time; if (fd_en) tmr0 = 20; end
    if (s1) begin ns1++; t_s1 = $time; if (fd_en) tmr1 = 20; end
    if (fe0) nfe0++;
    if (fe1) nfe1++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bclk period of 8 clk; lrclk and sdin change on the falling edge.
  task automatic bclk_bit(input logic lr, input logic b, input bit is_lsb);
    bclk  = 1'b0;
    lrclk = lr;
    sdin  = b;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (is_lsb) begin
      if (lr) t_lsb1 = $time;
      else    t_lsb0 = $time;
    end
    repeat (4) @(negedge clk);
  endtask

  // Period 0 carries the previous slot's last bit (I2S delay), then the word
  // MSB first, then pad bits for the rest of the slot.
  task automatic send_slot(input logic lr, input logic [23:0] w, input int n, input logic pad);
    logic b;
    for (int p = 0; p < n; p++) begin
      if (p == 0)       b = last_bit;
      else if (p <= 24) b = w[24-p];
      else              b = pad;
      bclk_bit(lr, b, p == 24);
      last_bit = b;
    end
  endtask

  task automatic send_frame(input logic [23:0] lw, input logic [23:0] rw, input int llen, input logic pad);
    send_slot(I2S_LEFT, lw, llen, pad);
    send_slot(I2S_RIGHT, rw, 32, pad);
  endtask

  typedef struct {
    logic [23:0] lw;
    logic [23:0] rw;
    int          llen;
    logic        pad;
    logic [23:0] exp0;
    logic [23:0] exp1;
    int          ens0;
    int          ens1;
    int          efe0;
    int          efe1;
  } vec_t;

  vec_t vecs[6];
  int   b0, b1, bf0, bf1;

  initial begin
    vecs[0] = '{24'hA55AC3, 24'h123456, 32, 1'b0, 24'hA55AC3, 24'h123456, 1, 1, 0, 0};
    vecs[1] = '{24'h800001, 24'h5A5A5A, 32, 1'b1, 24'h800001, 24'h5A5A5A, 1, 1, 0, 0};
    vecs[2] = '{24'h000001, 24'hFFFFFF, 32, 1'b0, 24'h000001, 24'hFFFFFF, 1, 1, 0, 0};
    vecs[3] = '{24'hA55AC3, 24'h123456, 32, 1'b0, 24'hA55AC3, 24'h123456, 1, 1, 0, 0};
    vecs[4] = '{24'h3C3C3C, 24'h654321, 11, 1'b0, 24'hA55AC3, 24'h654321, 0, 1, 1, 0};
    vecs[5] = '{24'h000F0F, 24'h0ABCDE, 32, 1'b0, 24'h000F0F, 24'h0ABCDE, 1, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset data0", 32'(d0), 32'h0);
    chk("reset data1", 32'(d1), 32'h0);
    chk("reset sample0", 32'(s0), 32'h0);
    chk("reset sample1", 32'(s1), 32'h0);
    chk("reset frame_err0", 32'(fe0), 32'h0);
    chk("reset frame_err1", 32'(fe1), 32'h0);
    chk("reset overrun0", 32'(ov0), 32'h0);
    chk("reset overrun1", 32'(ov1), 32'h0);
    reset = 1'b0;

    // Right slot first so the left channel sees a word-select change.
    send_slot(I2S_RIGHT, 24'h000000, 32, 1'b0);

    for (int i = 0; i < 6; i++) begin
      #2;
      b0 = ns0; b1 = ns1; bf0 = nfe0; bf1 = nfe1;
      send_frame(vecs[i].lw, vecs[i].rw, vecs[i].llen, vecs[i].pad);
      #2;
      chk($sformatf("row%0d data0", i), 32'(d0), 32'(vecs[i].exp0));
      chk($sformatf("row%0d data1", i), 32'(d1), 32'(vecs[i].exp1));
      chk($sformatf("row%0d samples0", i), 32'(ns0 - b0), 32'(vecs[i].ens0));
      chk($sformatf("row%0d samples1", i), 32'(ns1 - b1), 32'(vecs[i].ens1));
      chk($sformatf("row%0d frame_err0", i), 32'(nfe0 - bf0), 32'(vecs[i].efe0));
      chk($sformatf("row%0d frame_err1", i), 32'(nfe1 - bf1), 32'(vecs[i].efe1));
      chk($sformatf("row%0d overrun0", i), 32'(ov0), 32'h0);
      chk($sformatf("row%0d overrun1", i), 32'(ov1), 32'h0);
      if (vecs[i].ens0 == 1)
        chk($sformatf("row%0d latency0", i), 32'(t_s0 - t_lsb0), 32'((SYNC + 2) * CLK_P));
      if (vecs[i].ens1 == 1)
        chk($sformatf("row%0d latency1", i), 32'(t_s1 - t_lsb1), 32'((SYNC + 2) * CLK_P));
    end

    // Two frames with the filter never answering: the second sample overruns.
    #2;
    fd_en = 1'b0;
    send_frame(24'h111111, 24'h222222, 32, 1'b0);
    #2;
    chk("ovr first data0", 32'(d0), 32'h111111);
    chk("ovr first overrun0", 32'(ov0), 32'h0);
    chk("ovr first overrun1", 32'(ov1), 32'h0);
    send_frame(24'h333333, 24'h444444, 32, 1'b0);
    #2;
    chk("ovr second overrun0", 32'(ov0), 32'h1);
    chk("ovr second overrun1", 32'(ov1), 32'h1);
    fd_en = 1'b1;
    send_frame(24'h555555, 24'h666666, 32, 1'b0);
    #2;
    chk("ovr sticky overrun0", 32'(ov0), 32'h1);
    chk("ovr sticky data0", 32'(d0), 32'h555555);

    // Asynchronous reset with the left channel 12 bits into a word.
    send_slot(I2S_LEFT, 24'h5A3C96, 13, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("async rst data0", 32'(d0), 32'h0);
    chk("async rst data1", 32'(d1), 32'h0);
    chk("async rst overrun0", 32'(ov0), 32'h0);
    chk("async rst overrun1", 32'(ov1), 32'h0);
    chk("async rst sample0", 32'(s0), 32'h0);
    chk("async rst frame_err0", 32'(fe0), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    b0 = ns0; b1 = ns1; bf0 = nfe0; bf1 = nfe1;
    send_slot(I2S_RIGHT, 24'hDEAD01, 32, 1'b0);
    send_frame(24'h7FFFFF, 24'h13579B, 32, 1'b0);
    #2;
    chk("post rst data0", 32'(d0), 32'h7FFFFF);
    chk("post rst data1", 32'(d1), 32'h13579B);
    chk("post rst samples0", 32'(ns0 - b0), 32'd1);
    chk("post rst samples1", 32'(ns1 - b1), 32'd2);
    chk("post rst frame_err0", 32'(nfe0 - bf0), 32'd0);
    chk("post rst overrun0", 32'(ov0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
